// File: rtl/hvtx_island_sched.sv
// Data-island scheduler: opens HDMI data-island periods in horizontal blanking and shares the
// packet slots of each island between N_REQ sources in round-robin order. Outputs are registered.
module hvtx_island_sched #(
  parameter int unsigned WIDTH        = 12,
  parameter int unsigned FRAME_WIDTH  = 1650,
  parameter int unsigned ACTIVE_WIDTH = 1280,
  parameter int unsigned ISLAND_START = 1284,
  parameter int unsigned N_REQ        = 4,
  parameter int unsigned MAX_PACKETS  = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_x,
  input  logic [WIDTH-1:0] i_y,
  input  logic             i_enable,
  input  logic [N_REQ-1:0] i_req,
  output logic [1:0]       o_period,
  output logic [4:0]       o_beat,
  output logic [N_REQ-1:0] o_grant,
  output logic [N_REQ-1:0] o_ack,
  output logic             o_busy
);

  localparam int unsigned PktW = $clog2(MAX_PACKETS + 1);
  localparam int unsigned IdxW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [WIDTH-1:0] StartX = WIDTH'(ISLAND_START);

  localparam logic [1:0] PerCtl   = 2'd0;
  localparam logic [1:0] PerPre   = 2'd1;
  localparam logic [1:0] PerGuard = 2'd2;
  localparam logic [1:0] PerData  = 2'd3;

  if (ISLAND_START + 12 + 32 * MAX_PACKETS > FRAME_WIDTH - 10) begin : g_len_check
    $error("hvtx_island_sched: longest island overruns the video preamble");
  end
  if (ISLAND_START < ACTIVE_WIDTH + 4) begin : g_start_check
    $error("hvtx_island_sched: island preamble overlaps active video");
  end

  typedef enum logic [2:0] {StIdle, StPre, StLguard, StData, StTguard} state_e;

  state_e           state_q, state_d;
  logic [4:0]       cnt_q, cnt_d;
  logic [PktW-1:0]  pkts_q, pkts_d;
  logic [IdxW-1:0]  rr_q, rr_d;
  logic [1:0]       period_q, period_d;
  logic [4:0]       beat_q, beat_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [N_REQ-1:0] ack_q, ack_d;
  logic             busy_q, busy_d;

  logic [IdxW-1:0]  grant_idx, rr_next, sel_start;
  logic [N_REQ-1:0] sel_mask, sel_onehot;
  logic             sel_found;

  // Cursor y is only carried for debug visibility.
  logic unused_y;
  assign unused_y = ^i_y;

  function automatic logic [N_REQ-1:0] rr_pick(input logic [N_REQ-1:0] req,
                                               input logic [IdxW-1:0]  start);
    logic [N_REQ-1:0] pick;
    logic [IdxW-1:0]  idx;
    logic             found;
    pick  = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      idx = IdxW'((32'(start) + k) % N_REQ);
      if (!found && req[idx]) begin
        pick[idx] = 1'b1;
        found     = 1'b1;
      end
    end
    return pick;
  endfunction

  always_comb begin
    grant_idx = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (grant_q[i]) grant_idx = IdxW'(i);
    end
    rr_next = (32'(grant_idx) == N_REQ - 1) ? '0 : grant_idx + 1'b1;
    // At a packet boundary the source just acked may still request; skip it.
    sel_mask   = (state_q == StData) ? (i_req & ~grant_q) : i_req;
    sel_start  = (state_q == StData) ? rr_next : rr_q;
    sel_onehot = rr_pick(sel_mask, sel_start);
    sel_found  = |sel_onehot;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pkts_d  = pkts_q;
    rr_d    = rr_q;
    grant_d = grant_q;
    unique case (state_q)
      StIdle: begin
        if (i_x == StartX && i_enable && |i_req) begin
          state_d = StPre;
          cnt_d   = '0;
          pkts_d  = '0;
        end
      end
      StPre: begin
        if (cnt_q == 5'd7) begin
          state_d = StLguard;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      StLguard: begin
        if (cnt_q == 5'd1) begin
          cnt_d = '0;
          if (sel_found) begin
            state_d = StData;
            grant_d = sel_onehot;
          end else begin
            state_d = StTguard;
          end
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      StData: begin
        if (cnt_q == 5'd31) begin
          cnt_d  = '0;
          rr_d   = rr_next;
          pkts_d = pkts_q + 1'b1;
          if (32'(pkts_q) + 32'd1 < MAX_PACKETS && sel_found) begin
            grant_d = sel_onehot;
          end else begin
            state_d = StTguard;
            grant_d = '0;
          end
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      StTguard: begin
        if (cnt_q == 5'd1) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
        grant_d = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they land in the same cycle as the state.
  always_comb begin
    unique case (state_d)
      StPre:              period_d = PerPre;
      StLguard, StTguard: period_d = PerGuard;
      StData:             period_d = PerData;
      default:            period_d = PerCtl;
    endcase
    beat_d = (state_d == StData) ? cnt_d : 5'd0;
    ack_d  = (state_d == StData && cnt_d == 5'd31) ? grant_d : '0;
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      pkts_q   <= '0;
      rr_q     <= '0;
      period_q <= PerCtl;
      beat_q   <= '0;
      grant_q  <= '0;
      ack_q    <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pkts_q   <= pkts_d;
      rr_q     <= rr_d;
      period_q <= period_d;
      beat_q   <= beat_d;
      grant_q  <= grant_d;
      ack_q    <= ack_d;
      busy_q   <= busy_d;
    end
  end

  assign o_period = period_q;
  assign o_beat   = beat_q;
  assign o_grant  = grant_q;
  assign o_ack    = ack_q;
  assign o_busy   = busy_q;

endmodule

// File: tb/tb_hvtx_island_sched.sv
// Bench for hvtx_island_sched: directed island scenarios and a randomized multi-line sweep, every
// cycle checked against a model that derives the schedule from the offset since island start.
module tb_hvtx_island_sched;
  localparam int W    = 12;
  localparam int FW   = 1650;
  localparam int AW   = 1280;
  localparam int IS   = 1284;
  localparam int N    = 4;
  localparam int MAXP = 2;
  localparam int IW   = $clog2(N);

  logic         clk     = 1'b0;
  logic         rst_n   = 1'b0;
  logic [W-1:0] x       = '0;
  logic [W-1:0] y       = '0;
  logic         en      = 1'b1;
  logic [N-1:0] pending = '0;
  logic [1:0]   o_period;
  logic [4:0]   o_beat;
  logic [N-1:0] o_grant;
  logic [N-1:0] o_ack;
  logic         o_busy;

  always #5 clk = ~clk;

  hvtx_island_sched #(
    .WIDTH(W), .FRAME_WIDTH(FW), .ACTIVE_WIDTH(AW), .ISLAND_START(IS), .N_REQ(N),
    .MAX_PACKETS(MAXP)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_x(x), .i_y(y), .i_enable(en), .i_req(pending),
    .o_period(o_period), .o_beat(o_beat), .o_grant(o_grant), .o_ack(o_ack), .o_busy(o_busy)
  );

  int tests = 0;
  int fails = 0;

  // Reference model state: island offset, tail start, packets granted, RR pointer, owner.
  bit           m_act = 1'b0;
  int           m_off, m_tail, m_npk, m_cur;
  int           m_ptr = 0;
  logic [1:0]   m_period;
  logic [4:0]   m_beat;
  logic [N-1:0] m_grant, m_ack;
  logic         m_busy;

  bit           hold = 1'b0;
  bit           rnd  = 1'b0;
  int           busy_cnt, ack_cnt;
  logic [N-1:0] gq[$];

  function automatic logic [N-1:0] onehot(input int i);
    logic [N-1:0] v;
    v = '0;
    v[i[IW-1:0]] = 1'b1;
    return v;
  endfunction

  function automatic int pick(input logic [N-1:0] req, input int start);
    int idx;
    for (int k = 0; k < N; k++) begin
      idx = (start + k) % N;
      if (req[idx[IW-1:0]]) return idx;
    end
    return -1;
  endfunction

  task automatic model_step();
    if (!rst_n) begin
      m_act = 1'b0;
      m_ptr = 0;
    end else if (!m_act) begin
      if (x == IS && en && |pending) begin
        m_act = 1'b1; m_off = 0; m_tail = -1; m_npk = 0;
      end
    end else begin
      m_off++;
      if (m_tail >= 0 && m_off == m_tail + 2) begin
        m_act = 1'b0;
      end else if (m_tail < 0 && m_off >= 10 && (m_off - 10) % 32 == 0) begin
        if (m_npk == 0) begin
          m_cur = pick(pending, m_ptr);
        end else begin
          m_ptr = (m_cur + 1) % N;
          m_cur = (m_npk < MAXP) ? pick(pending & ~onehot(m_cur), m_ptr) : -1;
        end
        if (m_cur < 0) m_tail = m_off;
        else m_npk++;
      end
    end
    m_period = 2'd0; m_beat = 5'd0; m_grant = '0; m_ack = '0; m_busy = m_act;
    if (m_act) begin
      if (m_off < 8) m_period = 2'd1;
      else if (m_off < 10 || m_tail >= 0) m_period = 2'd2;
      else begin
        m_period = 2'd3;
        m_beat   = 5'((m_off - 10) % 32);
        m_grant  = onehot(m_cur);
        if (m_beat == 5'd31) m_ack = m_grant;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h (x=%0d)", tag, obs, exp, x);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    chk("period", 32'(o_period), 32'(m_period));
    chk("beat", 32'(o_beat), 32'(m_beat));
    chk("grant", 32'(o_grant), 32'(m_grant));
    chk("ack", 32'(o_ack), 32'(m_ack));
    chk("busy", 32'(o_busy), 32'(m_busy));
    chk("grant_onehot0", 32'($onehot0(o_grant)), 32'd1);
    busy_cnt += (o_period != 2'd0) ? 1 : 0;
    ack_cnt  += (o_ack != '0) ? 1 : 0;
    if (o_period == 2'd3 && o_beat == 5'd0) gq.push_back(o_grant);
    if (!hold) pending = pending & ~m_ack;
    if (rnd && $urandom_range(0, 299) == 0) pending = pending | onehot($urandom_range(0, N - 1));
    x = (x == W'(FW - 1)) ? '0 : x + 1'b1;
    if (x == '0) y = (y == W'(749)) ? '0 : y + 1'b1;
    // x now names the cycle whose outputs were just checked
    if (x < IS || x >= FW - 10) chk("window", 32'(o_period), 32'd0);
  endtask

  task automatic run_to(input int target);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (x != target && n < 2 * FW);
    if (x != target) chk("run_to_bound", 32'(x), 32'(target));
  endtask

  task automatic clr();
    busy_cnt = 0;
    ack_cnt  = 0;
    gq       = {};
  endtask

  initial begin
    clr();
    tick();
    tick();
    chk("rst_period", 32'(o_period), 32'd0);
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_grant", 32'(o_grant), 32'd0);
    rst_n = 1'b1;
    run_to(0);

    // Held 1011, two lines: RR 0 -> 1 within line, 3 -> 0 (wrap) on the next.
    hold = 1'b1; pending = 4'b1011; clr();
    run_to(0);
    chk("held1_len", 32'(busy_cnt), 32'd76);
    chk("held1_npk", 32'(gq.size()), 32'd2);
    chk("held1_g0", 32'(gq[0]), 32'b0001);
    chk("held1_g1", 32'(gq[1]), 32'b0010);
    clr();
    run_to(0);
    chk("held2_len", 32'(busy_cnt), 32'd76);
    chk("held2_g0", 32'(gq[0]), 32'b1000);
    chk("held2_g1", 32'(gq[1]), 32'b0001);
    hold = 1'b0; pending = '0;

    // Single request raised at x=1283.
    run_to(1283); pending = 4'b0001; clr();
    run_to(1285); chk("single_pre", 32'(o_period), 32'd1);
    run_to(1292); chk("single_pre_last", 32'(o_period), 32'd1);
    run_to(1293); chk("single_lguard", 32'(o_period), 32'd2);
    run_to(1295); chk("single_data", 32'(o_period), 32'd3);
    chk("single_grant", 32'(o_grant), 32'b0001);
    run_to(1326); chk("single_beat31", 32'(o_beat), 32'd31);
    chk("single_ack", 32'(o_ack), 32'b0001);
    run_to(1327); chk("single_tguard", 32'(o_period), 32'd2);
    run_to(1329); chk("single_ctl", 32'(o_period), 32'd0);
    run_to(0);
    chk("single_len", 32'(busy_cnt), 32'd44);

    // Request after the start cycle waits for the next line.
    run_to(1300); pending = 4'b0100; clr();
    run_to(0);
    chk("late_len", 32'(busy_cnt), 32'd0);
    clr();
    run_to(0);
    chk("late_next_len", 32'(busy_cnt), 32'd44);
    chk("late_next_g", 32'(gq[0]), 32'b0100);

    // Enable low at the start blocks; enable dropped mid-island does not abort.
    en = 1'b0; pending = 4'b0001; clr();
    run_to(0);
    chk("en_off_len", 32'(busy_cnt), 32'd0);
    en = 1'b1; clr();
    run_to(1300); en = 1'b0;
    run_to(0); en = 1'b1;
    chk("en_mid_len", 32'(busy_cnt), 32'd44);
    chk("en_mid_acks", 32'(ack_cnt), 32'd1);

    // Reset at DATA beat 10: no ack, source served again on the next line.
    pending = 4'b0010; clr();
    run_to(1305);
    chk("rst_mid_beat", 32'(o_beat), 32'd10);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("rst_mid_period", 32'(o_period), 32'd0);
    chk("rst_mid_grant", 32'(o_grant), 32'd0);
    chk("rst_mid_busy", 32'(o_busy), 32'd0);
    run_to(0);
    chk("rst_mid_noack", 32'(ack_cnt), 32'd0);
    clr();
    run_to(0);
    chk("rst_reserve_len", 32'(busy_cnt), 32'd44);
    chk("rst_reserve_g", 32'(gq[0]), 32'b0010);

    // Random sweep over a dozen lines.
    rnd = 1'b1;
    for (int l = 0; l < 12; l++) begin
      hold = ($urandom_range(0, 3) == 0);
      if (hold || $urandom_range(0, 1) == 1) pending = pending | N'($urandom_range(0, 15));
      en = ($urandom_range(0, 7) != 0);
      run_to(1290);
      en = ($urandom_range(0, 1) == 1);
      run_to(0);
    end
    rnd = 1'b0; hold = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
